// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Write-back queue between an execution producer and a register file.
//   Results are accepted into a small FIFO, committed to the register file one
//   per cycle (unless hold is high), and forwarded to the decode stage while
//   they are still pending.
//
// Ports
//   clock                   rising-edge clock
//   reset                   synchronous active-high reset
//   in_valid/in_ready       producer handshake for a {in_addr,in_data} result
//   hold                    freezes register-file writes (pushes continue)
//   WE/WR/WD                register-file write enable / address / data
//   fwd_addr1/fwd_addr2     decode-stage read addresses
//   fwd_hit1/fwd_hit2       a pending write targets the matching address
//   fwd_data1/fwd_data2     youngest pending data for that address, else 0
//   empty                   no pending writes
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hold,
  output logic              WE,
  output logic [ADDR_W-1:0] WR,
  output logic [DATA_W-1:0] WD,
  input  logic [ADDR_W-1:0] fwd_addr1,
  input  logic [ADDR_W-1:0] fwd_addr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              live;
  logic              push;
  logic              pop;

  // Handshake, commit port and occupancy flags. While reset is high every
  // output is forced to its idle value so a pending entry can never leak out
  // as a write in the reset cycle.
  always_comb begin
    live     = (count != {CNT_W{1'b0}}) && !reset;
    in_ready = reset || (count < FULL_CNT);
    empty    = reset || (count == {CNT_W{1'b0}});
    WE       = live && !hold;
    push     = in_valid && in_ready && !reset;
    pop      = WE;
    if (live) begin
      WR = addr_mem[rd_ptr];
      WD = data_mem[rd_ptr];
    end else begin
      WR = {ADDR_W{1'b0}};
      WD = {DATA_W{1'b0}};
    end
  end

  // Forwarding: walk entries oldest to youngest so the last match wins.
  // Only stored entries are searched, never the current in_* offer; the head
  // being popped this cycle is still stored and therefore still matches.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = {DATA_W{1'b0}};
    fwd_data2 = {DATA_W{1'b0}};
    idx       = {PTR_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (live && (CNT_W'(k) < count)) begin
        if (addr_mem[idx] == fwd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem[idx];
        end else begin
          fwd_hit1  = fwd_hit1;
        end
        if (addr_mem[idx] == fwd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem[idx];
        end else begin
          fwd_hit2  = fwd_hit2;
        end
      end else begin
        idx = idx;
      end
    end
  end

  // Pointer and occupancy state; DEPTH is a power of two so the pointers
  // wrap naturally at their width.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= {PTR_W{1'b0}};
      wr_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count defines validity.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= in_addr;
      data_mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_addr;
  logic [15:0] in_data;
  logic        hold;
  logic        WE;
  logic [2:0]  WR;
  logic [15:0] WD;
  logic [2:0]  fwd_addr1, fwd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [15:0] fwd_data1, fwd_data2;
  logic        empty;

  int checks = 0;
  int errors = 0;
  logic [18:0] commits [$];

  regfile_writeback #(.DEPTH(4), .DATA_W(16), .ADDR_W(3)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .WE(WE), .WR(WR), .WD(WD),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .empty(empty)
  );

  always #5 clock = ~clock;

  // Record every register-file commit seen at a rising edge.
  always @(posedge clock) begin
    if (WE === 1'b1) commits.push_back({WR, WD});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_addr = 3'd0; in_data = 16'h0000; hold = 1'b0;
    fwd_addr1 = 3'd0; fwd_addr2 = 3'd0;
    tick; tick;
    #1;
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL reset_during_we: got %0h expected 0", WE); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_during_empty: got %0h expected 1", empty); end
    reset = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0h expected 1", empty); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
    checks++; if ({WE, WR, WD} !== 20'h0) begin errors++; $display("FAIL reset_wport: got %h expected 0", {WE, WR, WD}); end
    checks++; if ({fwd_hit1, fwd_hit2, fwd_data1, fwd_data2} !== 34'h0) begin errors++; $display("FAIL reset_fwd: got %h expected 0", {fwd_hit1, fwd_hit2, fwd_data1, fwd_data2}); end
  endtask

  task automatic test_single;
    commits.delete();
    tick;
    in_valid = 1'b1; in_addr = 3'd3; in_data = 16'h1234; fwd_addr1 = 3'd3;
    #1;
    checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL single_no_fwd_offer: got %0h expected 0", fwd_hit1); end
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL single_we_before: got %0h expected 0", WE); end
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if ({WE, WR, WD} !== {1'b1, 3'd3, 16'h1234}) begin errors++; $display("FAIL single_write: got %h expected %h", {WE, WR, WD}, {1'b1, 3'd3, 16'h1234}); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_not_empty: got %0h expected 0", empty); end
    checks++; if ({fwd_hit1, fwd_data1} !== {1'b1, 16'h1234}) begin errors++; $display("FAIL single_fwd_popping_head: got %h expected %h", {fwd_hit1, fwd_data1}, {1'b1, 16'h1234}); end
    tick;
    #1;
    checks++; if ({empty, WE} !== 2'b10) begin errors++; $display("FAIL single_drained: got %b expected 10", {empty, WE}); end
    checks++; if (commits.size() !== 1) begin errors++; $display("FAIL single_commit_count: got %0d expected 1", commits.size()); end
    else begin
      checks++; if (commits[0] !== {3'd3, 16'h1234}) begin errors++; $display("FAIL single_commit: got %h expected %h", commits[0], {3'd3, 16'h1234}); end
    end
  endtask

  task automatic test_hold_full;
    commits.delete();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_addr = 3'(i); in_data = 16'h0100 + 16'(i);
      #1;
      checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL hold_in_ready_%0d: got %0h expected %0h", i, in_ready, (i < 4)); end
      checks++; if (WE !== 1'b0) begin errors++; $display("FAIL hold_we_%0d: got %0h expected 0", i, WE); end
      tick;
    end
    hold = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      checks++; if ({WE, WR, WD} !== {1'b1, 3'(j), 16'h0100 + 16'(j)}) begin errors++; $display("FAIL hold_release_%0d: got %h expected %h", j, {WE, WR, WD}, {1'b1, 3'(j), 16'h0100 + 16'(j)}); end
      if (j == 0) begin checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready_full_pop: got %0h expected 0", in_ready); end end
      if (j == 1) begin checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready_after_pop: got %0h expected 1", in_ready); end end
      tick;
      if (j == 1) in_valid = 1'b0;
    end
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL hold_drained: got %0h expected 1", empty); end
    checks++; if (commits.size() !== 5) begin errors++; $display("FAIL hold_commit_count: got %0d expected 5", commits.size()); end
  endtask

  task automatic test_forward;
    commits.delete();
    hold = 1'b1;
    in_valid = 1'b1; in_addr = 3'd2; in_data = 16'hAAAA; tick;
    in_data = 16'hBBBB; tick;
    in_valid = 1'b1; in_addr = 3'd6; in_data = 16'hCCCC;
    fwd_addr1 = 3'd2; fwd_addr2 = 3'd6;
    #1;
    checks++; if ({fwd_hit1, fwd_data1} !== {1'b1, 16'hBBBB}) begin errors++; $display("FAIL fwd_youngest: got %h expected %h", {fwd_hit1, fwd_data1}, {1'b1, 16'hBBBB}); end
    checks++; if ({fwd_hit2, fwd_data2} !== {1'b0, 16'h0000}) begin errors++; $display("FAIL fwd_miss: got %h expected %h", {fwd_hit2, fwd_data2}, {1'b0, 16'h0000}); end
    in_valid = 1'b0; hold = 1'b0;
    tick; tick;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_drained: got %0h expected 1", empty); end
    checks++; if (commits.size() !== 2) begin errors++; $display("FAIL fwd_commit_count: got %0d expected 2", commits.size()); end
    else begin
      checks++; if ({commits[0], commits[1]} !== {3'd2, 16'hAAAA, 3'd2, 16'hBBBB}) begin errors++; $display("FAIL fwd_commit_order: got %h expected %h", {commits[0], commits[1]}, {3'd2, 16'hAAAA, 3'd2, 16'hBBBB}); end
    end
  endtask

  task automatic test_full_stream;
    logic [18:0] exp_q [$];
    logic        rdy_exp;
    int          c;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_addr = 3'(i); in_data = 16'h0200 + 16'(i);
      exp_q.push_back({in_addr, in_data});
      tick;
    end
    hold = 1'b0;
    c = 4;
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = 1'b1; in_addr = 3'(c); in_data = 16'h0200 + 16'(c);
      #1;
      rdy_exp = (exp_q.size() < 4);
      checks++; if (in_ready !== rdy_exp) begin errors++; $display("FAIL stream_ready_%0d: got %0h expected %0h", cyc, in_ready, rdy_exp); end
      checks++; if ({WE, WR, WD} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL stream_write_%0d: got %h expected %h", cyc, {WE, WR, WD}, {1'b1, exp_q[0]}); end
      tick;
      void'(exp_q.pop_front());
      if (rdy_exp) begin
        exp_q.push_back({3'(c), 16'h0200 + 16'(c)});
        c++;
      end
    end
    in_valid = 1'b0;
    for (int g = 0; g < 8 && exp_q.size() > 0; g++) begin
      #1;
      checks++; if ({WE, WR, WD} !== {1'b1, exp_q[0]}) begin errors++; $display("FAIL stream_drain_%0d: got %h expected %h", g, {WE, WR, WD}, {1'b1, exp_q[0]}); end
      tick;
      void'(exp_q.pop_front());
    end
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty: got %0h expected 1", empty); end
  endtask

  task automatic test_reset_mid;
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_addr = 3'(i + 1); in_data = 16'hD001 + 16'(i);
      tick;
    end
    in_valid = 1'b0;
    commits.delete();
    hold = 1'b0; reset = 1'b1; fwd_addr1 = 3'd1;
    #1;
    checks++; if (WE !== 1'b0) begin errors++; $display("FAIL rstmid_we_during: got %0h expected 0", WE); end
    tick;
    reset = 1'b0;
    #1;
    checks++; if ({empty, WE, in_ready} !== 3'b101) begin errors++; $display("FAIL rstmid_state: got %b expected 101", {empty, WE, in_ready}); end
    checks++; if (fwd_hit1 !== 1'b0) begin errors++; $display("FAIL rstmid_fwd: got %0h expected 0", fwd_hit1); end
    tick; tick; tick;
    checks++; if (commits.size() !== 0) begin errors++; $display("FAIL rstmid_no_commits: got %0d expected 0", commits.size()); end
  endtask

  task automatic test_push_pop;
    commits.delete();
    hold = 1'b1;
    in_valid = 1'b1; in_addr = 3'd4; in_data = 16'h4400; tick;
    in_addr = 3'd5; in_data = 16'h5500; tick;
    hold = 1'b0; in_addr = 3'd6; in_data = 16'h6600;
    #1;
    checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL pp_count_before: got %0d expected 2", dut.count); end
    checks++; if ({WE, in_ready, WR} !== {1'b1, 1'b1, 3'd4}) begin errors++; $display("FAIL pp_handshake: got %h expected %h", {WE, in_ready, WR}, {1'b1, 1'b1, 3'd4}); end
    tick;
    in_valid = 1'b0;
    #1;
    checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL pp_count_after: got %0d expected 2", dut.count); end
    tick; tick;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_drained: got %0h expected 1", empty); end
    checks++; if (commits.size() !== 3) begin errors++; $display("FAIL pp_commit_count: got %0d expected 3", commits.size()); end
    else begin
      checks++; if ({commits[0], commits[1], commits[2]} !== {3'd4, 16'h4400, 3'd5, 16'h5500, 3'd6, 16'h6600}) begin errors++; $display("FAIL pp_order: got %h expected %h", {commits[0], commits[1], commits[2]}, {3'd4, 16'h4400, 3'd5, 16'h5500, 3'd6, 16'h6600}); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_hold_full;
    test_forward;
    test_full_stream;
    test_reset_mid;
    test_push_pop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
